if_id_decode: RTL

- IF/ID pipeline register plus primary instruction decoder for the MIPS core.
- Captures the fetched instruction and PC, then registers the decoded fields and control bits.
- Sits directly upstream of ImmediateExtender and drives its 16-bit immediate and ZeroExtend select; also feeds the register file read ports and the ID/EX register.
- Supports stall (hold), flush (bubble) and a saturating illegal-instruction counter.

---
 rtl/if_id_decode.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/if_id_decode.sv
// -----------------------------------------------------------------------------
// if_id_decode
//   IF/ID pipeline register and primary MIPS instruction decoder. The fetched
//   instruction and PC are captured, and the decoded register fields and
//   control bits are registered at the same edge (one cycle of latency).
//   The hazard unit can hold the stage (stall) or empty it (flush). A
//   saturating counter tracks accepted illegal instructions.
//
// Ports
//   clk, rst_n            rising-edge clock; synchronous active-low reset
//   if_valid/instr/pc     fetch-stage instruction, its PC, and a valid flag
//   stall, flush          hold / bubble requests (flush has priority)
//   if_ready              combinational ~stall; fetch advances when high
//   id_valid/pc/instr     registered instruction state
//   imm16, zero_extend    outputs to ImmediateExtender
//   rs, rt, rd, shamt     raw instruction register fields
//   dest_reg              write-back register index
//   reg_write .. jump     decoded control bits
//   illegal, ill_count    unsupported opcode/funct flag and saturating count
// -----------------------------------------------------------------------------
module if_id_decode #(
  parameter int unsigned ILL_CNT_W = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 if_ready,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic [15:0]          imm16,
  output logic                 zero_extend,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [4:0]           dest_reg,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 alu_src_imm,
  output logic                 branch,
  output logic                 jump,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_dest;
  logic       w_zext;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_alu_src_imm;
  logic       w_branch;
  logic       w_jump;
  logic       w_illegal;

  assign w_op    = if_instr[31:26];
  assign w_funct = if_instr[5:0];

  always_comb begin
    w_dest        = '0;
    w_zext        = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_alu_src_imm = 1'b0;
    w_branch      = 1'b0;
    w_jump        = 1'b0;
    w_illegal     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            w_reg_write = 1'b1;
            w_dest      = if_instr[15:11];
          end
          6'h08: begin
            w_jump = 1'b1;
            w_dest = if_instr[15:11];
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_reg_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_dest        = if_instr[20:16];
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_reg_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_dest        = if_instr[20:16];
        w_zext        = 1'b1;
      end
      OP_LW: begin
        w_mem_read    = 1'b1;
        w_reg_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_dest        = if_instr[20:16];
      end
      OP_SW: begin
        w_mem_write   = 1'b1;
        w_alu_src_imm = 1'b1;
      end
      OP_BEQ, OP_BNE: w_branch = 1'b1;
      OP_J:           w_jump   = 1'b1;
      OP_JAL: begin
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
        w_dest      = 5'd31;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic                 r_valid;
  logic [31:0]          r_pc;
  logic [31:0]          r_instr;
  logic [4:0]           r_dest;
  logic                 r_zext;
  logic                 r_reg_write;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic                 r_alu_src_imm;
  logic                 r_branch;
  logic                 r_jump;
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_ill_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_dest        <= '0;
      r_zext        <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_illegal     <= 1'b0;
      r_ill_count   <= '0;
    end else if (flush) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_instr       <= '0;
      r_dest        <= '0;
      r_zext        <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (!stall) begin
      // Raw fields follow the instruction even for a bubble; only the
      // control side is gated by if_valid.
      r_valid       <= if_valid;
      r_pc          <= if_pc;
      r_instr       <= if_instr;
      r_dest        <= w_dest;
      r_zext        <= w_zext        & if_valid;
      r_reg_write   <= w_reg_write   & if_valid;
      r_mem_read    <= w_mem_read    & if_valid;
      r_mem_write   <= w_mem_write   & if_valid;
      r_alu_src_imm <= w_alu_src_imm & if_valid;
      r_branch      <= w_branch      & if_valid;
      r_jump        <= w_jump        & if_valid;
      r_illegal     <= w_illegal     & if_valid;
      if (if_valid && w_illegal && (r_ill_count != '1))
        r_ill_count <= r_ill_count + ILL_CNT_W'(1);
    end
  end

  assign if_ready    = ~stall;
  assign id_valid    = r_valid;
  assign id_pc       = r_pc;
  assign id_instr    = r_instr;
  assign imm16       = r_instr[15:0];
  assign rs          = r_instr[25:21];
  assign rt          = r_instr[20:16];
  assign rd          = r_instr[15:11];
  assign shamt       = r_instr[10:6];
  assign dest_reg    = r_dest;
  assign zero_extend = r_zext;
  assign reg_write   = r_reg_write;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign alu_src_imm = r_alu_src_imm;
  assign branch      = r_branch;
  assign jump        = r_jump;
  assign illegal     = r_illegal;
  assign ill_count   = r_ill_count;

endmodule
